// File: rtl/dram_resp_pkg.sv
// dram_resp_pkg: shared defaults and port-grant encoding for the DRAM responder.
package dram_resp_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 18;
    localparam int DEF_RD_LAT     = 1;
    localparam int DEF_WB_DEPTH   = 4;
    typedef enum logic [1:0] {GNT_NONE, GNT_RD, GNT_DRAIN} gnt_e;
endpackage

// File: rtl/dram_wbuf.sv
// dram_wbuf: write-buffer FIFO with head outputs and youngest-match address lookup.
module dram_wbuf #(
    parameter int DW    = 32,
    parameter int AW    = 18,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    srstn,
    input  logic                    push_i,
    input  logic [AW-1:0]           push_addr_i,
    input  logic [DW-1:0]           push_data_i,
    input  logic                    pop_i,
    output logic [AW-1:0]           head_addr_o,
    output logic [DW-1:0]           head_data_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  count_o,
    input  logic [AW-1:0]           lk_addr_i,
    output logic                    lk_hit_o,
    output logic [DW-1:0]           lk_data_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + PW'(1);
            if (pop_i) head_q <= head_q + PW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
        end
    end
    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];
    assign full_o      = count_q == CW'(DEPTH);
    assign count_o     = count_q;
    // Walk oldest to youngest so the last match wins.
    always_comb begin
        lk_hit_o  = 1'b0;
        lk_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && addr_q[head_q + PW'(i)] == lk_addr_i) begin
                lk_hit_o  = 1'b1;
                lk_data_o = data_q[head_q + PW'(i)];
            end
        end
    end
endmodule

// File: rtl/dram_resp.sv
// dram_resp: single-port SRAM responder; reads win the port, writes buffer and drain
// on idle cycles, and reads forward from pending buffered writes.
module dram_resp
    import dram_resp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int WB_DEPTH   = DEF_WB_DEPTH
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  dram_en_rd,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  dram_en_wr,
    input  logic [ADDR_WIDTH-1:0] addr_out,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  req_ready,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  dram_valid,
    output logic                  idle,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int CW = $clog2(WB_DEPTH) + 1;
    logic                  wb_full, wb_hit, rd_acc, wr_acc;
    logic [CW-1:0]         wb_count;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data, hit_data;
    gnt_e                  gnt;
    logic [RD_LAT-1:0]     vld_q, fwd_q;
    logic [DATA_WIDTH-1:0] fdat_q [RD_LAT];
    logic                  dvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    assign req_ready = !wb_full;
    assign rd_acc    = dram_en_rd & req_ready;
    assign wr_acc    = dram_en_wr & req_ready;
    always_comb gnt = wb_full ? GNT_DRAIN : rd_acc ? GNT_RD : (wb_count != '0) ? GNT_DRAIN : GNT_NONE;
    assign mem_cs    = gnt != GNT_NONE;
    assign mem_we    = gnt == GNT_DRAIN;
    assign mem_addr  = (gnt == GNT_RD) ? addr_in : head_addr;
    assign mem_wdata = head_data;
    // Lookup sees only entries present before this edge, giving read-before-write.
    dram_wbuf #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH), .DEPTH(WB_DEPTH)) u_wbuf (
        .clk         (clk),
        .srstn       (srstn),
        .push_i      (wr_acc),
        .push_addr_i (addr_out),
        .push_data_i (data_out),
        .pop_i       (mem_we),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .full_o      (wb_full),
        .count_o     (wb_count),
        .lk_addr_i   (addr_in),
        .lk_hit_o    (wb_hit),
        .lk_data_o   (hit_data)
    );
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            vld_q    <= '0;
            fwd_q    <= '0;
            dvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            vld_q[0] <= rd_acc;
            fwd_q[0] <= wb_hit;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                fwd_q[i] <= fwd_q[i-1];
            end
            dvalid_q <= vld_q[RD_LAT-1];
            rdata_q  <= rdata_d;
        end
    end
    always_ff @(posedge clk) begin
        fdat_q[0] <= hit_data;
        for (int i = 1; i < RD_LAT; i++) fdat_q[i] <= fdat_q[i-1];
    end
    assign rdata_d    = !vld_q[RD_LAT-1] ? rdata_q : fwd_q[RD_LAT-1] ? fdat_q[RD_LAT-1] : mem_rdata;
    assign data_in    = rdata_q;
    assign dram_valid = dvalid_q;
    assign idle       = (wb_count == '0) & ~|vld_q & ~dvalid_q;
endmodule

// File: tb/tb_dram_resp.sv
// tb_dram_resp: directed table, corner sequences and random traffic against a
// coherent-memory reference model.
module tb_dram_resp;
    logic        clk = 1'b0;
    logic        srstn = 1'b0;
    logic        dram_en_rd = 1'b0, dram_en_wr = 1'b0;
    logic [17:0] addr_in = '0, addr_out = '0;
    logic [31:0] data_out = '0;
    logic        req_ready, dram_valid, idle, mem_cs, mem_we;
    logic [31:0] data_in, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [17:0] mem_addr;

    dram_resp dut (
        .clk(clk), .srstn(srstn), .dram_en_rd(dram_en_rd), .addr_in(addr_in),
        .dram_en_wr(dram_en_wr), .addr_out(addr_out), .data_out(data_out),
        .req_ready(req_ready), .data_in(data_in), .dram_valid(dram_valid), .idle(idle),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // SRAM macro with one cycle of read latency
    logic [31:0] sram [logic [17:0]];
    always @(posedge clk) begin
        if (mem_cs && mem_we) sram[mem_addr] = mem_wdata;
        if (mem_cs && !mem_we) mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : 32'h0;
    end

    // Reference: engines see one coherent memory; buffered writes persist only once drained.
    typedef struct { int due; logic [31:0] d; } rd_t;
    typedef struct { logic [17:0] a; logic [31:0] d; } wr_t;
    rd_t rq[$];
    wr_t wq[$];
    logic [31:0] ref_mem [logic [17:0]];
    logic [31:0] msram [logic [17:0]];
    logic [31:0] last_d = '0;
    int cyc = 0, dv_cnt = 0;
    bit m_rdy, m_rda, m_wra, m_drn;

    function automatic logic [31:0] rmem(input logic [17:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!srstn) begin
            wq.delete();
            rq.delete();
            ref_mem = msram;
            last_d = '0;
        end else begin
            m_rdy = wq.size() < 4;
            m_rda = dram_en_rd && m_rdy;
            m_wra = dram_en_wr && m_rdy;
            m_drn = !m_rdy || (!m_rda && wq.size() > 0);
            chk("req_ready", req_ready, m_rdy);
            chk("mem_cs", mem_cs, m_rda || m_drn);
            chk("mem_we", mem_we, m_drn);
            if (m_drn) begin
                chk("drain_addr", mem_addr, wq[0].a);
                chk("drain_data", mem_wdata, wq[0].d);
            end else if (m_rda) chk("rd_addr", mem_addr, addr_in);
            chk("idle", idle, wq.size() == 0 && rq.size() == 0);
            if (rq.size() > 0 && rq[0].due == cyc) begin
                chk("dram_valid", dram_valid, 1);
                chk("data_in", data_in, rq[0].d);
                last_d = rq[0].d;
                void'(rq.pop_front());
                dv_cnt++;
            end else begin
                chk("dram_valid", dram_valid, 0);
                chk("data_hold", data_in, last_d);
            end
            if (m_rda) rq.push_back('{cyc + 2, rmem(addr_in)});
            if (m_wra) ref_mem[addr_out] = data_out;
            if (m_drn) begin
                msram[wq[0].a] = wq[0].d;
                void'(wq.pop_front());
            end
            if (m_wra) wq.push_back('{addr_out, data_out});
        end
    end

    logic        s_ready, s_dv, s_idle, s_cs, s_we;
    logic [31:0] s_data;
    task automatic step(input bit rd, input logic [17:0] ra, input bit wr,
                        input logic [17:0] wa, input logic [31:0] wd);
        dram_en_rd = rd; addr_in = ra; dram_en_wr = wr; addr_out = wa; data_out = wd;
        @(negedge clk);
        s_ready = req_ready; s_dv = dram_valid; s_idle = idle;
        s_cs = mem_cs; s_we = mem_we; s_data = data_in;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit rd; logic [17:0] ra; bit wr; logic [17:0] wa; logic [31:0] wd;
        bit rdy; bit we; bit dv; logic [31:0] d;
    } vec_t;
    vec_t tbl[26];

    bit          prd, pwr, held;
    logic [17:0] pra, pwa;
    logic [31:0] pwd;
    int          dv0;

    initial begin
        for (int a = 0; a < 16; a++) sram[18'(a)] = $urandom;
        sram['h10] = 32'hA5A5_0001; sram['h11] = 32'h11; sram['h12] = 32'h12;
        sram['h20] = 32'hDEAD; sram['h30] = 32'h7; sram['h45] = 32'h45;
        for (int i = 0; i < 3; i++) sram[18'('h40 + i)] = 32'h4000 + i;
        for (int i = 0; i < 5; i++) sram[18'('h50 + i)] = 32'h5000 + i;
        for (int i = 0; i < 25; i++) sram[18'('h100 + i)] = 32'h1000 + i;
        ref_mem = sram;
        msram = sram;

        // latency, same-cycle read+write, forwarding, full buffer
        tbl[0]  = '{1, 'h10, 0, 0,    0,      1, 0, 0, 0};
        tbl[1]  = '{0, 0,    0, 0,    0,      1, 0, 0, 0};
        tbl[2]  = '{0, 0,    0, 0,    0,      1, 0, 1, 32'hA5A5_0001};
        tbl[3]  = '{0, 0,    0, 0,    0,      1, 0, 0, 32'hA5A5_0001};
        tbl[4]  = '{1, 'h30, 1, 'h30, 9,      1, 0, 0, 32'hA5A5_0001};
        tbl[5]  = '{1, 'h30, 0, 0,    0,      1, 0, 0, 32'hA5A5_0001};
        tbl[6]  = '{0, 0,    0, 0,    0,      1, 1, 1, 7};
        tbl[7]  = '{0, 0,    0, 0,    0,      1, 0, 1, 9};
        tbl[8]  = '{0, 0,    0, 0,    0,      1, 0, 0, 9};
        tbl[9]  = '{1, 'h11, 1, 'h20, 'h1111, 1, 0, 0, 9};
        tbl[10] = '{1, 'h12, 1, 'h20, 'h2222, 1, 0, 0, 9};
        tbl[11] = '{1, 'h20, 0, 0,    0,      1, 0, 1, 'h11};
        tbl[12] = '{0, 0,    0, 0,    0,      1, 1, 1, 'h12};
        tbl[13] = '{0, 0,    0, 0,    0,      1, 1, 1, 'h2222};
        tbl[14] = '{0, 0,    0, 0,    0,      1, 0, 0, 'h2222};
        tbl[15] = '{1, 'h50, 1, 'h60, 'hA,    1, 0, 0, 'h2222};
        tbl[16] = '{1, 'h51, 1, 'h61, 'hB,    1, 0, 0, 'h2222};
        tbl[17] = '{1, 'h52, 1, 'h62, 'hC,    1, 0, 1, 'h5000};
        tbl[18] = '{1, 'h53, 1, 'h63, 'hD,    1, 0, 1, 'h5001};
        tbl[19] = '{1, 'h54, 1, 'h64, 'hE,    0, 1, 1, 'h5002};
        tbl[20] = '{1, 'h54, 1, 'h64, 'hE,    1, 0, 1, 'h5003};
        tbl[21] = '{0, 0,    0, 0,    0,      0, 1, 0, 'h5003};
        tbl[22] = '{0, 0,    0, 0,    0,      1, 1, 1, 'h5004};
        tbl[23] = '{0, 0,    0, 0,    0,      1, 1, 0, 'h5004};
        tbl[24] = '{0, 0,    0, 0,    0,      1, 1, 0, 'h5004};
        tbl[25] = '{0, 0,    0, 0,    0,      1, 0, 0, 'h5004};

        step(0, 0, 0, 0, 0);
        chk("rst_dv", s_dv, 0); chk("rst_data", s_data, 0); chk("rst_idle", s_idle, 1);
        chk("rst_ready", s_ready, 1);
        step(0, 0, 0, 0, 0);
        srstn = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("post_rst_cs", s_cs, 0); chk("post_rst_we", s_we, 0);
        chk("post_rst_idle", s_idle, 1); chk("post_rst_ready", s_ready, 1);

        for (int t = 0; t < 26; t++) begin
            step(tbl[t].rd, tbl[t].ra, tbl[t].wr, tbl[t].wa, tbl[t].wd);
            chk($sformatf("tbl%0d_ready", t), s_ready, tbl[t].rdy);
            chk($sformatf("tbl%0d_we", t), s_we, tbl[t].we);
            chk($sformatf("tbl%0d_dv", t), s_dv, tbl[t].dv);
            chk($sformatf("tbl%0d_data", t), s_data, tbl[t].d);
        end

        // reset with three writes still buffered: they must be lost
        for (int i = 0; i < 3; i++) step(1, 'h45, 1, 18'('h40 + i), 32'hAAAA_0000 + i);
        dram_en_rd = 0; dram_en_wr = 0; srstn = 1'b0;
        @(negedge clk);
        chk("midrst_idle", idle, 1); chk("midrst_ready", req_ready, 1);
        chk("midrst_dv", dram_valid, 0); chk("midrst_data", data_in, 0);
        @(posedge clk);
        #1 srstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(i < 3, 18'('h40 + i), 0, 0, 0);
            if (i >= 2) chk($sformatf("midrst_rd%0d", i - 2), s_data, 32'h4000 + i - 2);
        end
        repeat (3) step(0, 0, 0, 0, 0);

        // streaming reads
        dv0 = dv_cnt;
        for (int i = 0; i < 25; i++) begin
            step(1, 18'('h100 + i), 0, 0, 0);
            chk($sformatf("strm_dv%0d", i), s_dv, i >= 2);
            if (i >= 2) chk($sformatf("strm_data%0d", i), s_data, 32'h1000 + i - 2);
        end
        step(0, 0, 0, 0, 0); chk("strm_tail_dv1", s_dv, 1); chk("strm_tail_idle1", s_idle, 0);
        step(0, 0, 0, 0, 0); chk("strm_tail_dv2", s_dv, 1); chk("strm_tail_idle2", s_idle, 0);
        step(0, 0, 0, 0, 0); chk("strm_end_dv", s_dv, 0); chk("strm_end_idle", s_idle, 1);
        chk("strm_count", 32'(dv_cnt - dv0), 25);

        // random traffic over a small address window; requests held while not ready
        held = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!held) begin
                prd = ($urandom_range(0, 99) < 55);
                pwr = ($urandom_range(0, 99) < 45);
                pra = 18'($urandom_range(0, 15));
                pwa = 18'($urandom_range(0, 15));
                pwd = $urandom;
            end
            step(prd, pra, pwr, pwa, pwd);
            held = (prd || pwr) && !s_ready;
        end
        repeat (8) step(0, 0, 0, 0, 0);
        chk("final_idle", s_idle, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
